axi_dram_responder: RTL and testbench
=====================================

# axi_dram_responder

AXI3 slave that answers the 64-bit burst reads and writes issued by `DRAMReader` and `DRAMWriter`. It stands in for the DRAM/PS port in simulation and standalone FPGA tests, and serves the full `IP_MAXI0_*` bundle from an internal byte-addressable memory.

## Interface

**Parameters**
- `ADDR_BASE`, default `32'h30008000`: byte address of memory word 0.
- `MEM_WORDS`, default 4096: depth in 64-bit words. Power of two, ≥16.
- `READ_LATENCY`, default 4: idle cycles between AR handshake and first `RVALID`. Range 0–255.

**Ports** (name, direction, width, meaning)
- `CLK` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `S_AXI_ARADDR` in 32, `S_AXI_ARLEN` in 4, `S_AXI_ARSIZE` in 2, `S_AXI_ARBURST` in 2, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out 64, `S_AXI_RRESP` out 2, `S_AXI_RLAST` out 1, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `S_AXI_AWADDR` in 32, `S_AXI_AWLEN` in 4, `S_AXI_AWSIZE` in 2, `S_AXI_AWBURST` in 2, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 64, `S_AXI_WSTRB` in 8, `S_AXI_WLAST` in 1, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `ERR` out 1: sticky flag. Set when any SLVERR is issued; cleared only by reset.

## Operation

- The read and write engines are independent FSMs. Each handles one burst at a time.
- **Read FSM: `R_IDLE → R_WAIT → R_BURST → R_IDLE`.**
  - `R_IDLE`: `ARREADY`=1. On handshake, latch addr, len (beats = len+1), and error status; clear the latency counter.
  - `R_WAIT`: count `READ_LATENCY` cycles. If `READ_LATENCY`=0, go directly to `R_BURST`.
  - `R_BURST`: `RVALID`=1, `RDATA`=mem[idx]. `RLAST`=1 on beat len. Advance only on `RVALID&&RREADY`. After the last beat, return to `R_IDLE`.
- **Write FSM: `W_IDLE → W_DATA → W_RESP → W_IDLE`.**
  - `W_IDLE`: `AWREADY`=1, `WREADY`=0. W beats arriving before AW are held off.
  - `W_DATA`: `WREADY`=1. On each W handshake, write bytes whose `WSTRB` bit is set (bit k ↔ `WDATA[8k+7:8k]`), then advance the beat. Exit after beat len.
  - `W_RESP`: `BVALID`=1 until `BREADY`, then return to `W_IDLE`.
- **Addressing:** idx = ((addr − `ADDR_BASE`) >> 3) + beat, taken modulo `MEM_WORDS`. This wraps inside the array and does not fault.
- **Error check** (per burst, evaluated at address handshake). SLVERR (`2'b10`) applies if any of these hold:
  - BURST≠INCR (`2'b01`);
  - SIZE≠`2'b11` (8 bytes);
  - addr < `ADDR_BASE`;
  - addr ≥ `ADDR_BASE` + 8·`MEM_WORDS`;
  - addr[2:0]≠0.
- **Error read burst:** still returns len+1 beats, each with `RDATA`=0 and `RRESP`=SLVERR.
- **Error write burst:** still consumes len+1 beats, writes nothing, and `BRESP`=SLVERR.
- **WLAST check:** `WLAST` must be 1 exactly on beat len. Any mismatch gives `BRESP`=SLVERR, but the data is still written.
- **Read/write collision:** a read beat and a write to the same word in the same cycle returns the old data (read-before-write).
- **Memory contents:** not reset, and not initialised. The bench preloads via hierarchical access.

## Timing

- **Reset values:** `ARREADY`=0, `AWREADY`=0, `RVALID`=0, `WREADY`=0, `BVALID`=0, `RLAST`=0, `RDATA`=0, `RRESP`=0, `BRESP`=0, `ERR`=0. Both FSMs are in IDLE. Both ready outputs rise on the first edge after `reset` deasserts.
- All outputs are registered.
- **Read latency:** AR handshake at edge n; first `RVALID` at edge n+1+`READ_LATENCY`. Back-to-back beats issue one per cycle while `RREADY`=1.
- **Read turnaround:** `ARREADY` returns the cycle after the last R handshake. There is no read pipelining.
- **Write latency:** `WREADY` rises the cycle after AW handshake. `BVALID` rises the cycle after the last W handshake. `AWREADY` returns the cycle after the B handshake.
- **Stall rules:** `RDATA`, `RRESP`, and `RLAST` stay stable while `RVALID && !RREADY`. `BRESP` stays stable while `BVALID && !BREADY`.
- **Reset mid-burst:** outputs go to reset values asynchronously. A partial write's already-committed beats remain in memory. No B response is issued.

## Structure

- **Package `axi_dram_pkg`:**
  - response constants: `RESP_OKAY`=`2'b00`, `RESP_SLVERR`=`2'b10`;
  - `BURST_INCR`=`2'b01`, `SIZE_8B`=`2'b11`;
  - typedefs for the read and write state enums;
  - a function `addr_err(addr, burst, size)`.
- **Sub-module `axi_dram_array`:** `MEM_WORDS`×64 memory with one synchronous read port, one write port with 8-bit byte enables, and read-before-write collision behaviour. The top level holds the two FSMs, beat counters, latency counter, and `ERR`.

## Test plan

1. **Preload and read:** preload mem[0..3]=`64'h11..`, `64'h22..`, `64'h33..`, `64'h44..`; read `ADDR_BASE`, ARLEN=3 → 4 beats in order, RRESP=0, `RLAST` only on beat 4, first `RVALID` exactly 1+4 cycles after AR.
2. **Write with strobes, then read back:** write `ADDR_BASE`+8, AWLEN=1, beat0 `WSTRB`=`8'h0F`, beat1 `WSTRB`=`8'hFF` → BRESP=0. Readback shows beat0 upper 4 bytes unchanged and beat1 fully updated.
3. **`RREADY` backpressure:** toggle `RREADY` 1,0,0,1,… during a 16-beat read → no beat dropped or duplicated, `RDATA` held during stalls.
4. **Error bursts:** read at `ADDR_BASE`−8 → 1 beat, `RDATA`=0, RRESP=`2'b10`, `ERR`=1. Write with AWBURST=`2'b00` → no memory change, BRESP=`2'b10`. Write with `WLAST` early on beat 0 of 2 → BRESP=`2'b10`.
5. **Collision and wrap:** simultaneous read and write of the same word → read returns the old value. A burst starting at word `MEM_WORDS`−2 with len=3 → accesses words `MEM_WORDS`−2, `MEM_WORDS`−1, 0, 1.
6. **Reset mid-burst:** assert `reset` during beat 5 of a 16-beat read → `RVALID`=0 immediately, `ARREADY`=1 on the first edge after release, and the next burst completes normally.

Source files
------------

// File: rtl/axi_dram_pkg.sv
// Shared constants, FSM state types and the burst legality check used by the
// simulated DRAM AXI3 slave.
package axi_dram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] SIZE_8B     = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // The served window is [base, limit); limit is 33 bits so it may end exactly at 4 GiB.
  function automatic logic addr_err(input logic [31:0] addr, input logic [1:0] burst,
                                    input logic [1:0] size, input logic [31:0] base,
                                    input logic [32:0] limit);
    return (burst != BURST_INCR) || (size != SIZE_8B) || (addr < base) ||
           ({1'b0, addr} >= limit) || (addr[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/axi_dram_array.sv
// 64-bit word memory with a registered read port and a byte-enabled write port.
// A read and a write to the same word in one cycle return the old contents.
module axi_dram_array #(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_idx,
  output logic [63:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [63:0]   wr_data,
  input  logic [7:0]    wr_strb
);

  logic [63:0] mem_q [MEM_WORDS];
  logic [63:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? 64'd0 : mem_q[rd_idx];
  end

  // The read register is reset so the bus data output is defined; the array itself is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= 64'd0;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (wr_en && wr_strb[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_dram_responder.sv
// AXI3 slave serving 64-bit INCR bursts from an internal memory, with independent
// read and write engines, fixed read latency and sticky error reporting.
module axi_dram_responder
  import axi_dram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h30008000,
  parameter int          MEM_WORDS    = 4096,
  parameter int          READ_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [3:0]  S_AXI_ARLEN,
  input  logic [1:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [3:0]  S_AXI_AWLEN,
  input  logic [1:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic        ERR
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + (33'(MEM_WORDS) << 3);
  localparam logic [7:0]  LAT        = 8'(READ_LATENCY);

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'((addr - ADDR_BASE) >> 3);
  endfunction

  rd_state_e     r_state_q, r_state_d;
  logic [AW-1:0] r_idx_q, r_idx_d;
  logic [3:0]    r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic          r_err_q, r_err_d;
  logic [7:0]    lat_cnt_q, lat_cnt_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;

  wr_state_e     w_state_q, w_state_d;
  logic [AW-1:0] w_idx_q, w_idx_d;
  logic [3:0]    w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic          w_err_q, w_err_d, wlast_bad_q, wlast_bad_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          err_q, err_d;

  logic          rd_en, rd_zero, wr_en, r_slverr, w_slverr, w_bad_now, w_fail;
  logic [AW-1:0] rd_idx;

  // Read engine: the memory read for a beat is issued on the edge that presents it.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_err_d   = r_err_q;
    lat_cnt_d = lat_cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rd_en     = 1'b0;
    rd_zero   = r_err_q;
    rd_idx    = r_idx_q;
    r_slverr  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arready_d = 1'b0;
          r_idx_d   = word_idx(S_AXI_ARADDR);
          r_len_d   = S_AXI_ARLEN;
          r_beat_d  = 4'd0;
          r_err_d   = addr_err(S_AXI_ARADDR, S_AXI_ARBURST, S_AXI_ARSIZE, ADDR_BASE, ADDR_LIMIT);
          lat_cnt_d = 8'd0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == LAT) begin
          rd_en     = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = (r_len_q == 4'd0);
          rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
          r_slverr  = r_err_q;
          r_state_d = R_BURST;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      R_BURST: begin
        if (S_AXI_RREADY) begin
          if (r_beat_q == r_len_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rd_en    = 1'b1;
            rd_idx   = r_idx_q + AW'(1);
            r_idx_d  = r_idx_q + AW'(1);
            r_beat_d = r_beat_q + 4'd1;
            rlast_d  = ((r_beat_q + 4'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write engine: a WLAST mismatch is remembered but never blocks the data itself.
  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    w_err_d     = w_err_q;
    wlast_bad_d = wlast_bad_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_en       = 1'b0;
    w_slverr    = 1'b0;
    w_bad_now   = (S_AXI_WLAST != (w_beat_q == w_len_q));
    w_fail      = w_err_q || wlast_bad_q || w_bad_now;
    unique case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (S_AXI_AWVALID && awready_q) begin
          awready_d   = 1'b0;
          wready_d    = 1'b1;
          w_idx_d     = word_idx(S_AXI_AWADDR);
          w_len_d     = S_AXI_AWLEN;
          w_beat_d    = 4'd0;
          w_err_d     = addr_err(S_AXI_AWADDR, S_AXI_AWBURST, S_AXI_AWSIZE, ADDR_BASE, ADDR_LIMIT);
          wlast_bad_d = 1'b0;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (S_AXI_WVALID && wready_q) begin
          wr_en = !w_err_q;
          if (w_beat_q == w_len_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_fail ? RESP_SLVERR : RESP_OKAY;
            w_slverr  = w_fail;
            w_state_d = W_RESP;
          end else begin
            w_beat_d    = w_beat_q + 4'd1;
            w_idx_d     = w_idx_q + AW'(1);
            wlast_bad_d = wlast_bad_q || w_bad_now;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    err_d = err_q || r_slverr || w_slverr;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;   r_idx_q <= '0;        r_len_q <= 4'd0;   r_beat_q <= 4'd0;
      r_err_q <= 1'b0;       lat_cnt_q <= 8'd0;    arready_q <= 1'b0; rvalid_q <= 1'b0;
      rlast_q <= 1'b0;       rresp_q <= RESP_OKAY;
      w_state_q <= W_IDLE;   w_idx_q <= '0;        w_len_q <= 4'd0;   w_beat_q <= 4'd0;
      w_err_q <= 1'b0;       wlast_bad_q <= 1'b0;  awready_q <= 1'b0; wready_q <= 1'b0;
      bvalid_q <= 1'b0;      bresp_q <= RESP_OKAY; err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d; r_idx_q <= r_idx_d;  r_len_q <= r_len_d; r_beat_q <= r_beat_d;
      r_err_q <= r_err_d;     lat_cnt_q <= lat_cnt_d; arready_q <= arready_d; rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;     rresp_q <= rresp_d;
      w_state_q <= w_state_d; w_idx_q <= w_idx_d;  w_len_q <= w_len_d; w_beat_q <= w_beat_d;
      w_err_q <= w_err_d;     wlast_bad_q <= wlast_bad_d; awready_q <= awready_d; wready_q <= wready_d;
      bvalid_q <= bvalid_d;   bresp_q <= bresp_d;  err_q <= err_d;
    end
  end

  axi_dram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .clk     (CLK),
    .rst     (reset),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_idx  (rd_idx),
    .rd_data (S_AXI_RDATA),
    .wr_en   (wr_en),
    .wr_idx  (w_idx_q),
    .wr_data (S_AXI_WDATA),
    .wr_strb (S_AXI_WSTRB)
  );

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_axi_dram_responder.sv
// Self-checking bench for axi_dram_responder: table of bursts checked against a
// reference memory through expected-beat queues, plus hand-built corner cases.
module tb_axi_dram_responder;

  localparam logic [31:0] BASE  = 32'h30008000;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] S_AXI_ARADDR = '0, S_AXI_AWADDR = '0;
  logic [3:0]  S_AXI_ARLEN = '0, S_AXI_AWLEN = '0;
  logic [1:0]  S_AXI_ARSIZE = '0, S_AXI_ARBURST = '0, S_AXI_AWSIZE = '0, S_AXI_AWBURST = '0;
  logic        S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0, S_AXI_AWVALID = 1'b0;
  logic [63:0] S_AXI_WDATA = '0;
  logic [7:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WLAST = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
  logic        S_AXI_ARREADY, S_AXI_RLAST, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY;
  logic        S_AXI_BVALID, ERR;
  logic [63:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP, S_AXI_BRESP;

  always #5 CLK = ~CLK;

  axi_dram_responder #(.ADDR_BASE(BASE), .MEM_WORDS(WORDS), .READ_LATENCY(LAT)) dut (
    .CLK(CLK), .reset(reset),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .ERR(ERR)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [1:0]  size;
    logic [7:0]  strb0;
    logic [7:0]  strb_rest;
    bit          wlast_early;
    bit          writes_mem;
    logic [1:0]  resp;
  } vec_t;

  rbeat_t      rexp_q[$];
  logic [1:0]  bexp_q[$];
  logic [63:0] model [WORDS];
  vec_t        vecs [14];
  int          checks = 0;
  int          errors = 0;
  logic        err_exp = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Used when an awaited handshake never arrives.
  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic int word_of(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 3;
    return int'(off % 32'(WORDS));
  endfunction

  // Drives one read burst; expected beats are queued before AR is presented.
  task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                            input logic [1:0] size, input logic [1:0] exp_resp, input bit toggle);
    int w, lat, got, cyc, p;
    rbeat_t e;
    logic [63:0] hd;
    logic [1:0] hr;
    logic hl;
    bit stalled;
    logic [3:0] pat;
    pat = 4'b1001;
    w = word_of(addr);
    for (int b = 0; b <= int'(len); b++) begin
      e.data = (exp_resp == 2'b10) ? 64'd0 : model[(w + b) % WORDS];
      e.resp = exp_resp;
      e.last = (b == int'(len));
      rexp_q.push_back(e);
    end
    @(negedge CLK);
    S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARSIZE = size;
    S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    cyc = 0;
    while (!S_AXI_ARREADY && cyc < 50) begin @(negedge CLK); cyc++; end
    if (!S_AXI_ARREADY) begin
      fail_now("ar_handshake");
      S_AXI_ARVALID = 1'b0;
      rexp_q.delete();
      return;
    end
    @(negedge CLK);
    S_AXI_ARVALID = 1'b0;
    lat = 0;
    while (!S_AXI_RVALID && lat < 300) begin @(negedge CLK); lat++; end
    check_output("r_latency", 64'(lat), 64'(1 + LAT));
    got = 0; p = 0; cyc = 0; stalled = 1'b0; hd = '0; hr = '0; hl = 1'b0;
    while (got <= int'(len) && cyc < 200) begin
      if (S_AXI_RVALID) begin
        if (stalled) begin
          check_output("r_stall_data", S_AXI_RDATA, hd);
          check_output("r_stall_resp_last", 64'({S_AXI_RRESP, S_AXI_RLAST}), 64'({hr, hl}));
        end
        S_AXI_RREADY = toggle ? pat[p % 4] : 1'b1;
        p++;
        if (S_AXI_RREADY) begin
          if (rexp_q.size() == 0) begin
            fail_now("r_extra_beat");
          end else begin
            e = rexp_q.pop_front();
            check_output("r_data", S_AXI_RDATA, e.data);
            check_output("r_resp", 64'(S_AXI_RRESP), 64'(e.resp));
            check_output("r_last", 64'(S_AXI_RLAST), 64'(e.last));
          end
          got++;
          stalled = 1'b0;
        end else begin
          hd = S_AXI_RDATA; hr = S_AXI_RRESP; hl = S_AXI_RLAST;
          stalled = 1'b1;
        end
      end
      @(negedge CLK);
      cyc++;
    end
    S_AXI_RREADY = 1'b0;
    if (got <= int'(len)) begin
      fail_now("r_beats");
      rexp_q.delete();
    end
    check_output("r_turnaround", 64'({S_AXI_RVALID, S_AXI_ARREADY}), 64'(2'b01));
  endtask

  // Drives one write burst; beat data is derived from the address and beat number.
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                             input logic [1:0] size, input logic [7:0] strb0, input logic [7:0] strb_rest,
                             input bit wlast_early, input bit writes_mem, input logic [1:0] exp_resp);
    int w, cyc;
    logic [63:0] d;
    logic [7:0] s;
    logic [1:0] eb, hb;
    w = word_of(addr);
    bexp_q.push_back(exp_resp);
    @(negedge CLK);
    S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWBURST = burst; S_AXI_AWSIZE = size;
    S_AXI_AWVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_AWREADY && cyc < 50) begin @(negedge CLK); cyc++; end
    if (!S_AXI_AWREADY) begin
      fail_now("aw_handshake");
      S_AXI_AWVALID = 1'b0;
      bexp_q.delete();
      return;
    end
    @(negedge CLK);
    S_AXI_AWVALID = 1'b0;
    check_output("w_ready_rise", 64'(S_AXI_WREADY), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      d = {addr, 24'hC0FFEE, 4'h0, 4'(b)};
      s = (b == 0) ? strb0 : strb_rest;
      S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
      S_AXI_WLAST = wlast_early ? (b == 0) : (b == int'(len));
      cyc = 0;
      while (!S_AXI_WREADY && cyc < 50) begin @(negedge CLK); cyc++; end
      if (!S_AXI_WREADY) begin
        fail_now("w_handshake");
        break;
      end
      if (writes_mem) begin
        for (int k = 0; k < 8; k++)
          if (s[k]) model[(w + b) % WORDS][8*k +: 8] = d[8*k +: 8];
      end
      @(negedge CLK);
    end
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    check_output("b_valid_rise", 64'(S_AXI_BVALID), 64'd1);
    cyc = 0;
    while (!S_AXI_BVALID && cyc < 50) begin @(negedge CLK); cyc++; end
    hb = S_AXI_BRESP;
    @(negedge CLK);
    check_output("b_stall_resp", 64'(S_AXI_BRESP), 64'(hb));
    S_AXI_BREADY = 1'b1;
    eb = bexp_q.pop_front();
    check_output("b_resp", 64'(S_AXI_BRESP), 64'(eb));
    @(negedge CLK);
    S_AXI_BREADY = 1'b0;
    check_output("b_turnaround", 64'({S_AXI_BVALID, S_AXI_AWREADY}), 64'(2'b01));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] old_val;
    logic [63:0] new_val;
    int cyc, got;

    // Burst table; expected responses are written out by hand.
    vecs[0]  = '{0, BASE,              4'd0 + 4'd3, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[1]  = '{1, BASE + 32'd8,      4'd1, 2'b01, 2'b11, 8'h0F, 8'hFF, 0, 1, 2'b00};
    vecs[2]  = '{0, BASE + 32'd8,      4'd1, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[3]  = '{0, BASE - 32'd8,      4'd0, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b10};
    vecs[4]  = '{1, BASE + 32'd16,     4'd0, 2'b00, 2'b11, 8'hFF, 8'hFF, 0, 0, 2'b10};
    vecs[5]  = '{0, BASE + 32'd16,     4'd0, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[6]  = '{1, BASE + 32'd24,     4'd1, 2'b01, 2'b11, 8'hFF, 8'hFF, 1, 1, 2'b10};
    vecs[7]  = '{0, BASE + 32'd24,     4'd1, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[8]  = '{0, BASE + 32'd4,      4'd0, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b10};
    vecs[9]  = '{0, BASE + 32'd32768,  4'd0, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b10};
    vecs[10] = '{0, BASE,              4'd0, 2'b01, 2'b10, 8'h00, 8'h00, 0, 0, 2'b10};
    vecs[11] = '{0, BASE + 32'd32752,  4'd3, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};
    vecs[12] = '{1, BASE + 32'd32752,  4'd3, 2'b01, 2'b11, 8'hFF, 8'hFF, 0, 1, 2'b00};
    vecs[13] = '{0, BASE + 32'd32752,  4'd3, 2'b01, 2'b11, 8'h00, 8'h00, 0, 0, 2'b00};

    for (int i = 0; i < WORDS; i++) model[i] = {32'hA5A50000 + 32'(i), ~32'(i)};
    model[0] = 64'h1111111111111111;
    model[1] = 64'h2222222222222222;
    model[2] = 64'h3333333333333333;
    model[3] = 64'h4444444444444444;
    for (int i = 0; i < WORDS; i++) dut.u_array.mem_q[i] = model[i];

    repeat (3) @(negedge CLK);
    check_output("reset_ctrl", 64'({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_RVALID, S_AXI_WREADY,
                                    S_AXI_BVALID, S_AXI_RLAST, S_AXI_RRESP, S_AXI_BRESP, ERR}), 64'd0);
    check_output("reset_rdata", S_AXI_RDATA, 64'd0);
    reset = 1'b0;
    @(negedge CLK);
    check_output("ready_after_reset", 64'({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}), 64'(3'b110));

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_write)
        write_burst(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size, vecs[i].strb0,
                    vecs[i].strb_rest, vecs[i].wlast_early, vecs[i].writes_mem, vecs[i].resp);
      else
        read_burst(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size, vecs[i].resp, 1'b0);
      if (vecs[i].resp == 2'b10) err_exp = 1'b1;
      check_output("err_flag", 64'(ERR), 64'(err_exp));
    end

    // 16-beat read with RREADY toggling 1,0,0,1 over words 16..31.
    read_burst(BASE + 32'd128, 4'd15, 2'b01, 2'b11, 2'b00, 1'b1);

    // Read load and write of word 40 land on the same edge; read must see the old value.
    old_val = model[40];
    new_val = 64'hDEADBEEF0BADF00D;
    @(negedge CLK);
    S_AXI_ARADDR = BASE + 32'd320; S_AXI_ARLEN = 4'd0; S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 2'b11;
    S_AXI_AWADDR = BASE + 32'd320; S_AXI_AWLEN = 4'd0; S_AXI_AWBURST = 2'b01; S_AXI_AWSIZE = 2'b11;
    S_AXI_ARVALID = 1'b1; S_AXI_AWVALID = 1'b1;
    check_output("col_idle", 64'({S_AXI_ARREADY, S_AXI_AWREADY}), 64'(2'b11));
    @(negedge CLK);
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0;
    repeat (LAT) @(negedge CLK);
    S_AXI_WDATA = new_val; S_AXI_WSTRB = 8'hFF; S_AXI_WLAST = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge CLK);
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    check_output("col_valids", 64'({S_AXI_RVALID, S_AXI_BVALID}), 64'(2'b11));
    check_output("col_old_data", S_AXI_RDATA, old_val);
    check_output("col_bresp", 64'(S_AXI_BRESP), 64'(2'b00));
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(negedge CLK);
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    model[40] = new_val;
    read_burst(BASE + 32'd320, 4'd0, 2'b01, 2'b11, 2'b00, 1'b0);

    // Reset asserted while beat 5 of a 16-beat read is on the bus.
    @(negedge CLK);
    S_AXI_ARADDR = BASE + 32'd128; S_AXI_ARLEN = 4'd15; S_AXI_ARBURST = 2'b01; S_AXI_ARSIZE = 2'b11;
    S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!S_AXI_ARREADY && cyc < 50) begin @(negedge CLK); cyc++; end
    @(negedge CLK);
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 100) begin
      if (S_AXI_RVALID) got++;
      @(negedge CLK);
      cyc++;
    end
    check_output("rst_beat5_valid", 64'(S_AXI_RVALID), 64'd1);
    check_output("rst_beat5_data", S_AXI_RDATA, model[20]);
    reset = 1'b1;
    #1;
    check_output("rst_async_ctrl", 64'({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RLAST, ERR}), 64'd0);
    check_output("rst_async_rdata", S_AXI_RDATA, 64'd0);
    S_AXI_RREADY = 1'b0;
    err_exp = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check_output("rst_release", 64'({S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_RVALID}), 64'(3'b110));
    read_burst(BASE, 4'd3, 2'b01, 2'b11, 2'b00, 1'b0);
    check_output("err_after_reset", 64'(ERR), 64'(err_exp));

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
